// File: rtl/bytecode_fetch.sv
// bytecode_fetch: walks the bytecode ROM from address 0 and hands one complete
// bytecode (opcode, operand count, up to two operands, opcode address) per
// valid/ready handshake to the ARM-generation stage. Stops on return (0xB1)
// or on an unsupported opcode.
//
// Handshake: out_valid is registered and only ever high in PRESENT. Once high,
// out_valid and every out_* field hold steady until the edge where
// out_valid & out_ready are both 1; that edge is the single transfer.
// out_ready is ignored in every other state.
module bytecode_fetch #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_opcode,
  output logic [1:0]            out_num_opd,
  output logic [7:0]            out_opd1,
  output logic [7:0]            out_opd2,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_OP   = 3'd1,
    S_LAT_OP  = 3'd2,
    S_RD_OPD  = 3'd3,
    S_LAT_OPD = 3'd4,
    S_PRESENT = 3'd5,
    S_HALT    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam logic [7:0] OP_RETURN = 8'hB1;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] op_pc_q;
  logic [7:0]            opcode_q;
  logic [1:0]            num_opd_q;
  logic [1:0]            rem_q;
  logic [7:0]            opd1_q;
  logic [7:0]            opd2_q;
  logic                  valid_q;
  logic                  done_q;
  logic                  illegal_q;

  logic                  op_legal_d;
  logic [1:0]            op_cnt_d;

  // Operand count of the supported opcodes; anything not listed is illegal.
  function automatic logic [2:0] decode(input logic [7:0] op);
    logic [2:0] r;
    r = 3'b000;
    case (op)
      8'h00, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
      8'h1A, 8'h1B, 8'h1C, 8'h1D,
      8'h3B, 8'h3C, 8'h3D, 8'h3E,
      8'h60, 8'hB1:              r = 3'b100;
      8'h10, 8'h15, 8'h36:       r = 3'b101;
      8'h11, 8'h84, 8'hA7:       r = 3'b110;
      default:                   r = 3'b000;
    endcase
    return r;
  endfunction

  // Decode the byte arriving from the ROM (meaningful in LAT_OP only).
  always_comb begin
    {op_legal_d, op_cnt_d} = decode(rom_data[7:0]);
  end

  // Fetch FSM: sequences opcode/operand reads and owns every output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      op_pc_q   <= '0;
      opcode_q  <= '0;
      num_opd_q <= '0;
      rem_q     <= '0;
      opd1_q    <= '0;
      opd2_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= S_RD_OP;
          end
        end
        // ROM samples rom_addr on this edge; data is usable in LAT_OP.
        S_RD_OP: state_q <= S_LAT_OP;
        S_LAT_OP: begin
          opcode_q <= rom_data[7:0];
          op_pc_q  <= pc_q;
          opd1_q   <= '0;
          opd2_q   <= '0;
          pc_q     <= pc_q + 1'b1;
          if (!op_legal_d) begin
            num_opd_q <= '0;
            illegal_q <= 1'b1;
            state_q   <= S_ERROR;
          end else if (op_cnt_d == 2'd0) begin
            num_opd_q <= 2'd0;
            valid_q   <= 1'b1;
            state_q   <= S_PRESENT;
          end else begin
            num_opd_q <= op_cnt_d;
            rem_q     <= op_cnt_d;
            state_q   <= S_RD_OPD;
          end
        end
        S_RD_OPD: state_q <= S_LAT_OPD;
        S_LAT_OPD: begin
          // rem_q equal to the full count means this is the first operand byte.
          if (rem_q == num_opd_q) opd1_q <= rom_data[7:0];
          else                    opd2_q <= rom_data[7:0];
          pc_q  <= pc_q + 1'b1;
          rem_q <= rem_q - 1'b1;
          if (rem_q == 2'd1) begin
            valid_q <= 1'b1;
            state_q <= S_PRESENT;
          end else begin
            state_q <= S_RD_OPD;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (opcode_q == OP_RETURN) begin
              done_q  <= 1'b1;
              state_q <= S_HALT;
            end else begin
              state_q <= S_RD_OP;
            end
          end
        end
        S_HALT, S_ERROR: begin
          if (start) begin
            pc_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            state_q   <= S_RD_OP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign out_valid   = valid_q;
  assign out_opcode  = opcode_q;
  assign out_num_opd = num_opd_q;
  assign out_opd1    = opd1_q;
  assign out_opd2    = opd2_q;
  assign out_pc      = op_pc_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Directed bench for bytecode_fetch: ROM models with 1-cycle read latency,
// an expected-transfer queue checked at every handshake, and hand-computed
// latency/spacing, backpressure, error, mid-fetch reset and PC-wrap cases.
module tb_bytecode_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, out_ready;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       out_valid;
  logic [7:0] out_opcode, out_opd1, out_opd2;
  logic [1:0] out_num_opd;
  logic [5:0] out_pc;
  logic       busy, done, illegal;
  logic [2:0] dbg_state;

  // Second instance with a 3-bit PC for the wrap case.
  logic       start2, out_ready2;
  logic [2:0] rom_addr2, out_pc2;
  logic [7:0] rom_data2, out_opcode2, out_opd1_2, out_opd2_2;
  logic       out_valid2, busy2, done2, illegal2;
  logic [1:0] out_num_opd2;
  logic [2:0] dbg_state2;

  bytecode_fetch #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_num_opd(out_num_opd), .out_opd1(out_opd1), .out_opd2(out_opd2), .out_pc(out_pc),
    .busy(busy), .done(done), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  bytecode_fetch #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut_w (
    .clk(clk), .reset(reset), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_opcode(out_opcode2),
    .out_num_opd(out_num_opd2), .out_opd1(out_opd1_2), .out_opd2(out_opd2_2), .out_pc(out_pc2),
    .busy(busy2), .done(done2), .illegal(illegal2), .dbg_state_o(dbg_state2)
  );

  // ROM models: register the word at the sampled address.
  logic [7:0] rom  [64];
  logic [7:0] rom2 [8];
  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] op, input logic [1:0] n,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] pc);
    return {op, n, a, b, pc};
  endfunction

  // Every handshake is compared against the front of the expected queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_xfer++;
      acc_q.push_back(cyc);
      if (exp_q.size() == 0)
        check("xfer_extra", 32'(exp_q.size()), 32'd1);
      else
        check("xfer", {out_opcode, out_num_opd, out_opd1, out_opd2, out_pc}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_xfer = 0;
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 64; i++) rom[i] = 8'hFF;
  endtask

  task automatic pulse_start(output int start_cyc);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done || illegal) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_timeout"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fields"}, {out_opcode, out_num_opd, out_opd1, out_opd2, out_pc}, 32'd0);
    check({tag, "_flags"}, {22'd0, rom_addr, out_valid, busy, done, illegal}, 32'd0);
    check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int          sc;
  logic [31:0] snap_f, snap_c;
  logic        seen;

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    start2 = 1'b0; out_ready2 = 1'b1;
    fill_rom();
    for (int i = 0; i < 8; i++) rom2[i] = 8'h00;
    do_reset();
    check_reset_state("reset");

    // Three 0-operand bytecodes, ready held high.
    fill_rom();
    rom[0] = 8'h03; rom[1] = 8'h3B; rom[2] = 8'hB1;
    exp_q.push_back(pack(8'h03, 2'd0, 8'h00, 8'h00, 6'd0));
    exp_q.push_back(pack(8'h3B, 2'd0, 8'h00, 8'h00, 6'd1));
    exp_q.push_back(pack(8'hB1, 2'd0, 8'h00, 8'h00, 6'd2));
    pulse_start(sc);
    wait_end("t1", 100);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_count", n_xfer, 32'd3);
    check("t1_lat0", acc_q[0] - sc, 32'd3);
    check("t1_gap1", acc_q[1] - acc_q[0], 32'd3);
    check("t1_gap2", acc_q[2] - acc_q[1], 32'd3);
    check("t1_valid_low", {31'd0, out_valid}, 32'd0);

    // Backpressure on the first PRESENT.
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(pack(8'h03, 2'd0, 8'h00, 8'h00, 6'd0));
    exp_q.push_back(pack(8'h3B, 2'd0, 8'h00, 8'h00, 6'd1));
    exp_q.push_back(pack(8'hB1, 2'd0, 8'h00, 8'h00, 6'd2));
    pulse_start(sc);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin seen = 1'b1; break; end
      tick();
    end
    check("bp_valid_seen", {31'd0, seen}, 32'd1);
    snap_f = {out_opcode, out_num_opd, out_opd1, out_opd2, out_pc};
    snap_c = {25'd0, rom_addr, out_valid};
    check("bp_snap_fields", snap_f, pack(8'h03, 2'd0, 8'h00, 8'h00, 6'd0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_fields", {out_opcode, out_num_opd, out_opd1, out_opd2, out_pc}, snap_f);
      check("bp_hold_ctrl", {25'd0, rom_addr, out_valid}, snap_c);
    end
    out_ready = 1'b1;
    wait_end("bp", 100);
    check("bp_count", n_xfer, 32'd3);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // 1- and 2-operand bytecodes, then return.
    do_reset();
    rom[0] = 8'h10; rom[1] = 8'h2A; rom[2] = 8'h11; rom[3] = 8'h01; rom[4] = 8'h2C; rom[5] = 8'hB1;
    exp_q.push_back(pack(8'h10, 2'd1, 8'h2A, 8'h00, 6'd0));
    exp_q.push_back(pack(8'h11, 2'd2, 8'h01, 8'h2C, 6'd2));
    exp_q.push_back(pack(8'hB1, 2'd0, 8'h00, 8'h00, 6'd5));
    pulse_start(sc);
    wait_end("t2", 100);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_count", n_xfer, 32'd3);
    check("t2_lat0", acc_q[0] - sc, 32'd5);
    check("t2_gap1", acc_q[1] - acc_q[0], 32'd7);
    check("t2_gap2", acc_q[2] - acc_q[1], 32'd3);

    // Illegal opcode after iconst_1, then restart.
    do_reset();
    fill_rom();
    rom[0] = 8'h04; rom[1] = 8'hFF;
    exp_q.push_back(pack(8'h04, 2'd0, 8'h00, 8'h00, 6'd0));
    pulse_start(sc);
    wait_end("ill", 100);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_opcode", {24'd0, out_opcode}, 32'hFF);
    check("ill_valid_done_busy", {29'd0, out_valid, done, busy}, 32'd0);
    check("ill_pc", {26'd0, out_pc}, 32'd1);
    check("ill_count", n_xfer, 32'd1);
    exp_q.push_back(pack(8'h04, 2'd0, 8'h00, 8'h00, 6'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ill_restart_flag", {31'd0, illegal}, 32'd0);
    check("ill_restart_addr", {26'd0, rom_addr}, 32'd0);
    check("ill_restart_busy", {31'd0, busy}, 32'd1);
    wait_end("ill2", 100);
    check("ill2_flag", {31'd0, illegal}, 32'd1);
    check("ill2_count", n_xfer, 32'd2);

    // Reset asserted in LAT_OPD of sipush, then refetch.
    do_reset();
    fill_rom();
    rom[0] = 8'h10; rom[1] = 8'h2A; rom[2] = 8'h11; rom[3] = 8'h01; rom[4] = 8'h2C; rom[5] = 8'hB1;
    exp_q.push_back(pack(8'h10, 2'd1, 8'h2A, 8'h00, 6'd0));
    pulse_start(sc);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dbg_state == 3'd4 && out_opcode == 8'h11) begin seen = 1'b1; break; end
      tick();
    end
    check("rmid_reached", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rmid");
    check("rmid_count", n_xfer, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid | busy;
    end
    check("rmid_quiet", {31'd0, seen}, 32'd0);
    n_xfer = 0;
    acc_q.delete();
    exp_q.push_back(pack(8'h10, 2'd1, 8'h2A, 8'h00, 6'd0));
    exp_q.push_back(pack(8'h11, 2'd2, 8'h01, 8'h2C, 6'd2));
    exp_q.push_back(pack(8'hB1, 2'd0, 8'h00, 8'h00, 6'd5));
    pulse_start(sc);
    wait_end("rmid2", 100);
    check("rmid2_done", {31'd0, done}, 32'd1);
    check("rmid2_count", n_xfer, 32'd3);
    check("rmid2_lat0", acc_q[0] - sc, 32'd5);

    // PC wrap with a 3-bit address: bipush at 7, operand at 0.
    rom2[0] = 8'h03;
    for (int i = 1; i < 7; i++) rom2[i] = 8'h00;
    rom2[7] = 8'h10;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid2 && out_pc2 == 3'd7) begin seen = 1'b1; break; end
      tick();
    end
    check("wrap_reached", {31'd0, seen}, 32'd1);
    check("wrap_fields", {out_opcode2, out_num_opd2, out_opd1_2, out_opd2_2, 3'd0, out_pc2},
          pack(8'h10, 2'd1, 8'h03, 8'h00, 6'd7));
    check("wrap_next_addr", {29'd0, rom_addr2}, 32'd1);
    check("wrap_illegal", {31'd0, illegal2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: stop a run that somehow never reaches the summary.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected end within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bytecode_fetch.md
# bytecode_fetch

Front-end stage of the Java-to-ARM translator. It walks the bytecode ROM from address 0, reads each opcode and its operand bytes, and presents one complete bytecode (opcode, operand count, up to two operands) per handshake to the ARM-generation stage. It stops on `return` (0xB1) or on an opcode outside the supported set.

## Interface
- `ADDR_WIDTH`, default 6: ROM address width; the PC wraps modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 8: ROM word width. Fixed at 8; any other value is unsupported.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high; forces IDLE and clears all registers.
- `start`  in  1: level; sampled only in IDLE, HALT and ERROR.
- `rom_addr`  out  ADDR_WIDTH: equals the PC register. The ROM registers `rom_data` on the edge after it samples `rom_addr`.
- `rom_data`  in  8: ROM read data; 1-cycle latency.
- `out_valid`  out  1: the bytecode fields are valid.
- `out_ready`  in  1: the downstream stage accepts the bytecode.
- `out_opcode`  out  8: opcode.
- `out_num_opd`  out  2: operand count, 0 to 2.
- `out_opd1`  out  8: first byte after the opcode (high byte for 2-byte operands); 0 if unused.
- `out_opd2`  out  8: second byte after the opcode; 0 if unused.
- `out_pc`  out  ADDR_WIDTH: address of the opcode byte.
- `busy`  out  1: the state is not IDLE, HALT or ERROR.
- `done`  out  1: high in HALT.
- `illegal`  out  1: high in ERROR.

## Operation
- Decode table (operand count):
  - Count 0: 0x00 nop; 0x03–0x08 iconst_0..5; 0x1A–0x1D iload_0..3; 0x3B–0x3E istore_0..3; 0x60 iadd; 0xB1 return.
  - Count 1: 0x10 bipush; 0x15 iload; 0x36 istore.
  - Count 2: 0x11 sipush; 0x84 iinc; 0xA7 goto.
  - Any other opcode is illegal.
- States and transitions:
  - IDLE: if `start`, PC<=0 and go to RD_OP.
  - RD_OP: ROM samples the PC; go to LAT_OP.
  - LAT_OP: latch `rom_data` into the opcode register and `out_pc`<=PC; clear both operand registers; PC<=PC+1.
    - Illegal opcode: go to ERROR.
    - Count 0: go to PRESENT.
    - Count 1 or 2: set the remaining-operand counter to the count and go to RD_OPD.
  - RD_OPD: go to LAT_OPD.
  - LAT_OPD: latch `rom_data` into opd1 on the first operand, opd2 on the second; PC<=PC+1; decrement the remaining counter. If the counter is now 0 go to PRESENT, else go to RD_OPD.
  - PRESENT: `out_valid`=1; fields are held stable. When `out_ready`=1: if the opcode is 0xB1, go to HALT; otherwise go to RD_OP.
  - HALT: `done`=1. ERROR: `illegal`=1 and `out_opcode` holds the offending byte. In both, `start` sets PC<=0 and goes to RD_OP, clearing `done`/`illegal`.
- PC arithmetic is ADDR_WIDTH-bit unsigned. Incrementing from 2^ADDR_WIDTH−1 gives 0, with no error; this applies to opcode and operand bytes alike.
- `return` is presented downstream before HALT is entered.

## Timing
- Reset values: `rom_addr`=0, `out_valid`=0, `out_opcode`/`out_opd1`/`out_opd2`=0, `out_num_opd`=0, `out_pc`=0, `busy`=0, `done`=0, `illegal`=0.
- Reset has priority over every other input in every state, including mid-fetch and during PRESENT with `out_ready`=1. No bytecode is presented after reset until `start`.
- Latency from `start` sampled in IDLE:
  - IDLE→RD_OP on the first edge; the first `out_valid` is 3 cycles after the `start` edge for a 0-operand opcode.
  - Each operand adds 2 cycles.
- Sustained throughput with `out_ready` held high: 3 cycles per 0-operand bytecode, 5 per 1-operand, 7 per 2-operand.
- `out_valid` is registered, derived from state. Once high, it stays high and all fields stay stable until the accepting edge (`out_valid` & `out_ready`). `out_valid` is never asserted in any state other than PRESENT.
- `out_ready` is ignored outside PRESENT. `start` is ignored while `busy`.

## Test plan
- ROM = {0x03, 0x3B, 0xB1}, `out_ready`=1, pulse `start`.
  - Three transfers: (0x03,0,pc0), (0x3B,0,pc1), (0xB1,0,pc2).
  - `out_valid` is high 3 cycles after `start`, then every 3 cycles; `done`=1 after the third transfer.
- ROM = {0x10, 0x2A, 0x11, 0x01, 0x2C, 0xB1}.
  - Transfers: bipush with opd1=0x2A, opd2=0, pc0; sipush with opd1=0x01, opd2=0x2C, pc2; then return at pc5.
  - Spacing is 5 cycles, then 7, then 3.
- Backpressure: hold `out_ready`=0 for 10 cycles during the first PRESENT.
  - `out_valid` and all fields stay constant and `rom_addr` does not change.
  - After `out_ready` rises, exactly one transfer occurs with no duplicate.
- ROM = {0x04, 0xFF}: after the iconst_1 transfer, `illegal`=1 with `out_opcode`=0xFF and `out_valid`=0.
  - Then `start` restarts from PC 0 and clears `illegal`.
- Assert `reset` for 1 cycle in LAT_OPD of sipush.
  - Next cycle: all outputs equal their reset values and the state is IDLE.
  - `start` then refetches from address 0.
- Wrap: with ADDR_WIDTH=3 and a 0x10 opcode at address 7 whose operand sits at address 0, opd1=rom[0] and `out_pc`=7.
